pipeline_control_unit: RTL and testbench

//  Consumer of the main decoder's control word in the 5-stage RV32I pipeline. Registers control

---
 rtl/riscv_ctrl_pkg.sv | 49 ++++
 rtl/hazard_forward_unit.sv | 66 ++++++
 rtl/pipeline_control_unit.sv | 113 +++++++++++
 tb/tb_pipeline_control_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared control-word types and constants for the RV32I pipeline control path.
// The decoder and the pipeline control unit both import this package.
package riscv_ctrl_pkg;

   localparam int REG_AW_DEF = 5;
   localparam int CTRL_W_DEF = 12;

   // Field order matches the decoder's packed control word, MSB first.
   typedef struct packed {
      logic       branch;
      logic       mem_read;
      logic       mem_to_reg;
      logic [2:0] alu_op;
      logic       mem_write;
      logic       alu_src;
      logic       reg_write;
      logic [1:0] auipc_lui;
      logic       jump;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '0;

   localparam logic [6:0] OPC_R     = 7'b0110011;
   localparam logic [6:0] OPC_I     = 7'b0010011;
   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_S     = 7'b0100011;
   localparam logic [6:0] OPC_B     = 7'b1100011;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_JAL   = 7'b1101111;
   localparam logic [6:0] OPC_JALR  = 7'b1100111;

   localparam logic [2:0] ALUOP_ADD    = 3'b000;
   localparam logic [2:0] ALUOP_BRANCH = 3'b001;
   localparam logic [2:0] ALUOP_RTYPE  = 3'b010;
   localparam logic [2:0] ALUOP_ITYPE  = 3'b011;
   localparam logic [2:0] ALUOP_PASS   = 3'b100;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_t;

   function automatic logic redirects(input ctrl_t c, input logic zero);
      return c.jump | (c.branch & zero);
   endfunction

endpackage

// File: rtl/hazard_forward_unit.sv
// Combinational hazard detection, branch/jump resolution and ALU operand
// forwarding selects, computed from the pipeline stage registers.
module hazard_forward_unit
   import riscv_ctrl_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic              ex_mem_read,
   input  logic              ex_branch,
   input  logic              ex_jump,
   input  logic              ex_zero,
   input  logic              mem_reg_write,
   input  logic              wb_reg_write,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic [REG_AW-1:0] ex_rs1,
   input  logic [REG_AW-1:0] ex_rs2,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   output logic              load_use,
   output logic              pc_src,
   output fwd_sel_t          fwd_a,
   output fwd_sel_t          fwd_b
);

   logic [REG_AW-1:0] ex_rs [2];
   fwd_sel_t          fwd_sel [2];
   logic              mem_live;
   logic              wb_live;

   assign ex_rs[0] = ex_rs1;
   assign ex_rs[1] = ex_rs2;

   // x0 is hardwired zero, so a write to it is never a source of fresh data.
   assign mem_live = mem_reg_write & (mem_rd != '0);
   assign wb_live  = wb_reg_write  & (wb_rd  != '0);

   always_comb begin
      load_use = 1'b0;
      if (ex_mem_read && (ex_rd != '0) && id_valid &&
          ((ex_rd == id_rs1) || (ex_rd == id_rs2))) begin
         load_use = 1'b1;
      end
   end

   assign pc_src = ex_jump | (ex_branch & ex_zero);

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
         always_comb begin
            fwd_sel[gi] = FWD_RF;
            if (mem_live && (mem_rd == ex_rs[gi])) begin
               fwd_sel[gi] = FWD_MEM;
            end else if (wb_live && (wb_rd == ex_rs[gi])) begin
               fwd_sel[gi] = FWD_WB;
            end
         end
      end
   endgenerate

   assign fwd_a = fwd_sel[0];
   assign fwd_b = fwd_sel[1];

endmodule

// File: rtl/pipeline_control_unit.sv
// Carries decoder control and rd through ID/EX, EX/MEM and MEM/WB and drives
// stall, flush, PC-select and forwarding controls for the datapath.
module pipeline_control_unit
   import riscv_ctrl_pkg::*;
#(
   parameter int REG_AW = REG_AW_DEF,
   parameter int CTRL_W = CTRL_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              ex_zero,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [CTRL_W-1:0] mem_ctrl,
   output logic [CTRL_W-1:0] wb_ctrl,
   output logic [REG_AW-1:0] ex_rd,
   output logic [REG_AW-1:0] mem_rd,
   output logic [REG_AW-1:0] wb_rd,
   output logic              pc_write,
   output logic              ifid_write,
   output logic              ifid_flush,
   output logic              pc_src,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b
);

   typedef struct packed {
      ctrl_t             ctrl;
      logic [REG_AW-1:0] rd;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
   } ex_stage_t;

   typedef struct packed {
      ctrl_t             ctrl;
      logic [REG_AW-1:0] rd;
   } late_stage_t;

   ex_stage_t   ex_reg, ex_next;
   late_stage_t mem_reg, wb_reg;

   logic     load_use;
   logic     redirect;
   logic     bubble;
   fwd_sel_t fwd_a_sel, fwd_b_sel;

   hazard_forward_unit #(
      .REG_AW (REG_AW)
   ) u_hazard (
      .ex_mem_read   (ex_reg.ctrl.mem_read),
      .ex_branch     (ex_reg.ctrl.branch),
      .ex_jump       (ex_reg.ctrl.jump),
      .ex_zero       (ex_zero),
      .mem_reg_write (mem_reg.ctrl.reg_write),
      .wb_reg_write  (wb_reg.ctrl.reg_write),
      .ex_rd         (ex_reg.rd),
      .mem_rd        (mem_reg.rd),
      .wb_rd         (wb_reg.rd),
      .ex_rs1        (ex_reg.rs1),
      .ex_rs2        (ex_reg.rs2),
      .id_valid      (id_valid),
      .id_rs1        (id_rs1),
      .id_rs2        (id_rs2),
      .load_use      (load_use),
      .pc_src        (redirect),
      .fwd_a         (fwd_a_sel),
      .fwd_b         (fwd_b_sel)
   );

   // A taken redirect squashes the ID instruction, so it overrides the stall.
   assign bubble = load_use | redirect | ~id_valid;

   always_comb begin
      ex_next = '0;
      if (!bubble) begin
         ex_next.ctrl = ctrl_t'(id_ctrl);
         ex_next.rd   = id_rd;
         ex_next.rs1  = id_rs1;
         ex_next.rs2  = id_rs2;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_reg  <= '0;
         mem_reg <= '0;
         wb_reg  <= '0;
      end else begin
         ex_reg       <= ex_next;
         mem_reg.ctrl <= ex_reg.ctrl;
         mem_reg.rd   <= ex_reg.rd;
         wb_reg       <= mem_reg;
      end
   end

   assign ex_ctrl    = ex_reg.ctrl;
   assign mem_ctrl   = mem_reg.ctrl;
   assign wb_ctrl    = wb_reg.ctrl;
   assign ex_rd      = ex_reg.rd;
   assign mem_rd     = mem_reg.rd;
   assign wb_rd      = wb_reg.rd;
   assign pc_src     = redirect;
   assign ifid_flush = redirect;
   assign pc_write   = ~(load_use & ~redirect);
   assign ifid_write = ~(load_use & ~redirect);
   assign fwd_a      = fwd_a_sel;
   assign fwd_b      = fwd_b_sel;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Directed-vector bench for pipeline_control_unit: a table of per-cycle
// stimulus with hand-computed outputs, then hazard and reset sequences.
module tb_pipeline_control_unit;

   localparam logic [11:0] C_NOP = 12'h000;
   localparam logic [11:0] C_R   = 12'h008;  // RegWrite, ALUOp=000
   localparam logic [11:0] C_LW  = 12'h618;  // MemRead, MemtoReg, ALUSrc, RegWrite
   localparam logic [11:0] C_BEQ = 12'h840;  // Branch, ALUOp=001
   localparam logic [11:0] C_JAL = 12'h009;  // RegWrite, Jump
   localparam logic [11:0] C_MRJ = 12'h401;  // MemRead with Jump, to force both hazards

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] id_ctrl;
   logic        id_valid;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        ex_zero;
   logic [11:0] ex_ctrl, mem_ctrl, wb_ctrl;
   logic [4:0]  ex_rd, mem_rd, wb_rd;
   logic        pc_write, ifid_write, ifid_flush, pc_src;
   logic [1:0]  fwd_a, fwd_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipeline_control_unit dut (
      .clk        (clk),
      .rst        (rst),
      .id_ctrl    (id_ctrl),
      .id_valid   (id_valid),
      .id_rs1     (id_rs1),
      .id_rs2     (id_rs2),
      .id_rd      (id_rd),
      .ex_zero    (ex_zero),
      .ex_ctrl    (ex_ctrl),
      .mem_ctrl   (mem_ctrl),
      .wb_ctrl    (wb_ctrl),
      .ex_rd      (ex_rd),
      .mem_rd     (mem_rd),
      .wb_rd      (wb_rd),
      .pc_write   (pc_write),
      .ifid_write (ifid_write),
      .ifid_flush (ifid_flush),
      .pc_src     (pc_src),
      .fwd_a      (fwd_a),
      .fwd_b      (fwd_b)
   );

   typedef struct {
      logic [11:0] ctrl;
      logic        valid;
      logic [4:0]  rs1, rs2, rd;
      logic        zero;
      logic [11:0] e_ex, e_mem, e_wb;
      logic [4:0]  e_exrd, e_memrd, e_wbrd;
      logic        e_pcw, e_redir;
      logic [1:0]  e_fa, e_fb;
   } vec_t;

   localparam int NV = 21;
   vec_t vecs [NV];

   function automatic vec_t mk(
      input logic [11:0] c, input logic v, input logic [4:0] r1, r2, rd, input logic z,
      input logic [11:0] ee, em, ew, input logic [4:0] erd, mrd, wrd,
      input logic pcw, redir, input logic [1:0] fa, fb);
      vec_t t;
      t.ctrl = c; t.valid = v; t.rs1 = r1; t.rs2 = r2; t.rd = rd; t.zero = z;
      t.e_ex = ee; t.e_mem = em; t.e_wb = ew;
      t.e_exrd = erd; t.e_memrd = mrd; t.e_wbrd = wrd;
      t.e_pcw = pcw; t.e_redir = redir; t.e_fa = fa; t.e_fb = fb;
      return t;
   endfunction

   task automatic check(input string name, input int idx, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic [11:0] c, input logic v, input logic [4:0] r1, r2, rd,
                        input logic z);
      id_ctrl = c; id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rd = rd; ex_zero = z;
   endtask

   initial begin
      //              ctrl   v  rs1 rs2 rd z   ex     mem    wb     exrd mrd wrd pcw rd  fa fb
      vecs[0]  = mk(C_R,   1, 1, 2, 5, 0, C_NOP, C_NOP, C_NOP, 0, 0, 0, 1, 0, 0, 0);
      vecs[1]  = mk(C_R,   1, 5, 7, 6, 0, C_R,   C_NOP, C_NOP, 5, 0, 0, 1, 0, 0, 0);
      vecs[2]  = mk(C_R,   0, 0, 0, 9, 0, C_R,   C_R,   C_NOP, 6, 5, 0, 1, 0, 2, 0);
      vecs[3]  = mk(C_R,   1, 6, 5, 3, 0, C_NOP, C_R,   C_R,   0, 6, 5, 1, 0, 0, 0);
      vecs[4]  = mk(C_LW,  1, 2, 0, 5, 0, C_R,   C_NOP, C_R,   3, 0, 6, 1, 0, 1, 0);
      vecs[5]  = mk(C_R,   1, 5, 1, 7, 0, C_LW,  C_R,   C_NOP, 5, 3, 0, 0, 0, 0, 0);
      vecs[6]  = mk(C_R,   1, 5, 1, 7, 0, C_NOP, C_LW,  C_R,   0, 5, 3, 1, 0, 0, 0);
      vecs[7]  = mk(C_BEQ, 1, 7, 3, 0, 0, C_R,   C_NOP, C_LW,  7, 0, 5, 1, 0, 1, 0);
      vecs[8]  = mk(C_R,   1, 1, 1, 8, 1, C_BEQ, C_R,   C_NOP, 0, 7, 0, 1, 1, 2, 0);
      vecs[9]  = mk(C_BEQ, 1, 3, 4, 0, 0, C_NOP, C_BEQ, C_R,   0, 0, 7, 1, 0, 0, 0);
      vecs[10] = mk(C_R,   1, 2, 2, 9, 0, C_BEQ, C_NOP, C_BEQ, 0, 0, 0, 1, 0, 0, 0);
      vecs[11] = mk(C_LW,  1, 9, 0, 4, 0, C_R,   C_BEQ, C_NOP, 9, 0, 0, 1, 0, 0, 0);
      vecs[12] = mk(C_JAL, 1, 0, 0, 1, 0, C_LW,  C_R,   C_BEQ, 4, 9, 0, 1, 0, 2, 0);
      vecs[13] = mk(C_R,   1, 1, 4, 2, 0, C_JAL, C_LW,  C_R,   1, 4, 9, 1, 1, 0, 0);
      vecs[14] = mk(C_R,   1, 4, 1, 3, 0, C_NOP, C_JAL, C_LW,  0, 1, 4, 1, 0, 0, 0);
      vecs[15] = mk(C_R,   1, 0, 0, 3, 0, C_R,   C_NOP, C_JAL, 3, 0, 1, 1, 0, 0, 1);
      vecs[16] = mk(C_R,   1, 3, 0, 3, 0, C_R,   C_R,   C_NOP, 3, 3, 0, 1, 0, 0, 0);
      vecs[17] = mk(C_R,   1, 0, 0, 0, 0, C_R,   C_R,   C_R,   3, 3, 3, 1, 0, 2, 0);
      vecs[18] = mk(C_R,   1, 0, 0, 0, 0, C_R,   C_R,   C_R,   0, 3, 3, 1, 0, 0, 0);
      vecs[19] = mk(C_R,   1, 0, 3, 0, 0, C_R,   C_R,   C_R,   0, 0, 3, 1, 0, 0, 0);
      vecs[20] = mk(C_R,   0, 0, 0, 0, 0, C_R,   C_R,   C_R,   0, 0, 0, 1, 0, 0, 0);

      // Reset state with a would-be instruction presented in ID.
      rst = 1'b1;
      drive(C_LW, 1, 5, 5, 5, 1);
      @(negedge clk);
      @(negedge clk);
      #1;
      check("rst_ex_ctrl", 0, ex_ctrl, C_NOP);
      check("rst_mem_ctrl", 0, mem_ctrl, C_NOP);
      check("rst_wb_ctrl", 0, wb_ctrl, C_NOP);
      check("rst_ex_rd", 0, ex_rd, 0);
      check("rst_mem_rd", 0, mem_rd, 0);
      check("rst_wb_rd", 0, wb_rd, 0);
      check("rst_pc_write", 0, pc_write, 1);
      check("rst_ifid_write", 0, ifid_write, 1);
      check("rst_ifid_flush", 0, ifid_flush, 0);
      check("rst_pc_src", 0, pc_src, 0);
      check("rst_fwd_a", 0, fwd_a, 0);
      check("rst_fwd_b", 0, fwd_b, 0);
      @(negedge clk);
      drive(C_NOP, 0, 0, 0, 0, 0);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         drive(vecs[i].ctrl, vecs[i].valid, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].zero);
         #1;
         $display("vec %0d ctrl=%03h v=%0b rs1=%0d rs2=%0d rd=%0d z=%0b -> ex=%03h mem=%03h wb=%03h pcw=%0b src=%0b fa=%0d fb=%0d",
                  i, vecs[i].ctrl, vecs[i].valid, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
                  vecs[i].zero, ex_ctrl, mem_ctrl, wb_ctrl, pc_write, pc_src, fwd_a, fwd_b);
         check("ex_ctrl", i, ex_ctrl, vecs[i].e_ex);
         check("mem_ctrl", i, mem_ctrl, vecs[i].e_mem);
         check("wb_ctrl", i, wb_ctrl, vecs[i].e_wb);
         check("ex_rd", i, ex_rd, vecs[i].e_exrd);
         check("mem_rd", i, mem_rd, vecs[i].e_memrd);
         check("wb_rd", i, wb_rd, vecs[i].e_wbrd);
         check("pc_write", i, pc_write, vecs[i].e_pcw);
         check("ifid_write", i, ifid_write, vecs[i].e_pcw);
         check("pc_src", i, pc_src, vecs[i].e_redir);
         check("ifid_flush", i, ifid_flush, vecs[i].e_redir);
         check("fwd_a", i, fwd_a, vecs[i].e_fa);
         check("fwd_b", i, fwd_b, vecs[i].e_fb);
      end

      // Load-use and jump together in EX: the redirect wins, no stall.
      @(negedge clk);
      drive(C_MRJ, 1, 0, 0, 5, 0);
      @(negedge clk);
      drive(C_R, 1, 5, 0, 2, 0);
      #1;
      $display("seq both: ex=%03h pcw=%0b ifw=%0b src=%0b flush=%0b",
               ex_ctrl, pc_write, ifid_write, pc_src, ifid_flush);
      check("both_ex_ctrl", 0, ex_ctrl, C_MRJ);
      check("both_pc_src", 0, pc_src, 1);
      check("both_ifid_flush", 0, ifid_flush, 1);
      check("both_pc_write", 0, pc_write, 1);
      check("both_ifid_write", 0, ifid_write, 1);
      @(negedge clk);
      #1;
      check("both_bubble_ctrl", 0, ex_ctrl, C_NOP);
      check("both_bubble_rd", 0, ex_rd, 0);

      // A load targeting x0 never stalls.
      drive(C_LW, 1, 1, 0, 0, 0);
      @(negedge clk);
      drive(C_R, 1, 0, 0, 4, 0);
      #1;
      $display("seq x0 load: ex=%03h ex_rd=%0d pcw=%0b", ex_ctrl, ex_rd, pc_write);
      check("x0_load_in_ex", 0, ex_ctrl, C_LW);
      check("x0_load_pc_write", 0, pc_write, 1);
      check("x0_load_ifid_write", 0, ifid_write, 1);

      // Asynchronous reset mid-stream, while a load-use stall is active.
      @(negedge clk);
      drive(C_LW, 1, 1, 0, 5, 0);
      @(negedge clk);
      drive(C_R, 1, 5, 0, 6, 0);
      #1;
      check("pre_rst_stall", 0, pc_write, 0);
      check("pre_rst_ex_ctrl", 0, ex_ctrl, C_LW);
      #1;
      rst = 1'b1;
      #1;
      $display("seq async rst: ex=%03h mem=%03h wb=%03h pcw=%0b", ex_ctrl, mem_ctrl, wb_ctrl,
               pc_write);
      check("arst_ex_ctrl", 0, ex_ctrl, C_NOP);
      check("arst_mem_ctrl", 0, mem_ctrl, C_NOP);
      check("arst_wb_ctrl", 0, wb_ctrl, C_NOP);
      check("arst_ex_rd", 0, ex_rd, 0);
      check("arst_pc_write", 0, pc_write, 1);
      check("arst_ifid_write", 0, ifid_write, 1);
      @(negedge clk);
      rst = 1'b0;
      drive(C_R, 1, 0, 0, 6, 0);
      @(negedge clk);
      #1;
      $display("seq resume: ex=%03h ex_rd=%0d", ex_ctrl, ex_rd);
      check("resume_ex_ctrl", 0, ex_ctrl, C_R);
      check("resume_ex_rd", 0, ex_rd, 6);
      check("resume_mem_ctrl", 0, mem_ctrl, C_NOP);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
